// File: rtl/usb_tx_ctrl.sv
// rtl/usb_tx_ctrl.sv - USB TX packet sequencer: SYNC, PID, payload, optional CRC16, EOP.
// Optional CRC16 generation and append is enabled by defining USB_TX_CRC16_EN.
module usb_tx_ctrl #(
  parameter int MAX_BYTES = 64,
  parameter int EOP_BITS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_len,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  input  logic       shift_enable,
  input  logic       byte_sent,
  output logic       enable_timer,
  output logic [7:0] tx_byte,
  output logic       load_byte,
  output logic       eop_se0,
  output logic       eop_j,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int EW = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;
  localparam logic [EW-1:0] EOP_LAST = EW'(EOP_BITS - 1);
  localparam logic [6:0]    MAX_LEN  = 7'(MAX_BYTES);

`ifdef USB_TX_CRC16_EN
  typedef enum logic [3:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, J, ABORT} state_t;
`else
  typedef enum logic [3:0] {IDLE, SYNC, PID, DATA, EOP, J, ABORT} state_t;
`endif

  function automatic logic is_hs(input logic [3:0] p);
    return (p == 4'h2) || (p == 4'hA) || (p == 4'hE);
  endfunction

  function automatic logic is_data(input logic [3:0] p);
    return (p == 4'h3) || (p == 4'hB);
  endfunction

  state_t        state, state_n;
  logic [3:0]    pid_q, pid_n;
  logic [6:0]    rem, rem_n;
  logic [EW-1:0] eop_cnt, eop_cnt_n;
  logic [7:0]    tx_byte_n;
  logic          load_n, rd_n, en_n, se0_n, j_n, done_n, err_n;
  logic          start_ok;

  assign start_ok = (state == IDLE) && tx_start && (is_hs(tx_pid) || is_data(tx_pid));
  assign tx_busy  = (state != IDLE);

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc;

  // Reflected form of x^16+x^15+x^2+1, consuming the byte LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_n   = state;
    pid_n     = pid_q;
    rem_n     = rem;
    eop_cnt_n = eop_cnt;
    tx_byte_n = tx_byte;
    load_n    = 1'b0;
    rd_n      = 1'b0;
    en_n      = enable_timer;
    se0_n     = eop_se0;
    j_n       = eop_j;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n   = SYNC;
          pid_n     = tx_pid;
          rem_n     = is_data(tx_pid) ? ((tx_len > MAX_LEN) ? MAX_LEN : tx_len) : 7'd0;
          eop_cnt_n = '0;
          tx_byte_n = 8'h80;
          load_n    = 1'b1;
          en_n      = 1'b1;
        end
      end
      SYNC: begin
        if (byte_sent) begin
          state_n   = PID;
          tx_byte_n = {~pid_q, pid_q};
          load_n    = 1'b1;
        end
      end
      // Each byte_sent here is the load point for the following byte.
      PID, DATA: begin
        if (byte_sent) begin
          if (rem == 7'd0) begin
`ifdef USB_TX_CRC16_EN
            if (is_data(pid_q)) begin
              state_n   = CRC_LO;
              tx_byte_n = ~crc[7:0];
              load_n    = 1'b1;
            end else begin
              state_n = EOP;
              se0_n   = 1'b1;
            end
`else
            state_n = EOP;
            se0_n   = 1'b1;
`endif
          end else if (fifo_empty) begin
            state_n = ABORT;
            en_n    = 1'b0;
            se0_n   = 1'b1;
          end else begin
            state_n   = DATA;
            tx_byte_n = fifo_rdata;
            load_n    = 1'b1;
            rd_n      = 1'b1;
            rem_n     = rem - 7'd1;
          end
        end
      end
`ifdef USB_TX_CRC16_EN
      CRC_LO: begin
        if (byte_sent) begin
          state_n   = CRC_HI;
          tx_byte_n = ~crc[15:8];
          load_n    = 1'b1;
        end
      end
      CRC_HI: begin
        if (byte_sent) begin
          state_n = EOP;
          se0_n   = 1'b1;
        end
      end
`endif
      EOP: begin
        if (shift_enable) begin
          if (eop_cnt == EOP_LAST) begin
            state_n   = J;
            eop_cnt_n = '0;
            se0_n     = 1'b0;
            j_n       = 1'b1;
          end else begin
            eop_cnt_n = eop_cnt + 1'b1;
          end
        end
      end
      J: begin
        if (shift_enable) begin
          state_n = IDLE;
          j_n     = 1'b0;
          en_n    = 1'b0;
          done_n  = 1'b1;
        end
      end
      ABORT: begin
        state_n = IDLE;
        se0_n   = 1'b0;
        err_n   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pid_q        <= 4'h0;
      rem          <= 7'd0;
      eop_cnt      <= '0;
      tx_byte      <= 8'h00;
      load_byte    <= 1'b0;
      fifo_rd      <= 1'b0;
      enable_timer <= 1'b0;
      eop_se0      <= 1'b0;
      eop_j        <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      state        <= state_n;
      pid_q        <= pid_n;
      rem          <= rem_n;
      eop_cnt      <= eop_cnt_n;
      tx_byte      <= tx_byte_n;
      load_byte    <= load_n;
      fifo_rd      <= rd_n;
      enable_timer <= en_n;
      eop_se0      <= se0_n;
      eop_j        <= j_n;
      tx_done      <= done_n;
      tx_error     <= err_n;
    end
  end

`ifdef USB_TX_CRC16_EN
  // The popped byte is still held in tx_byte during the fifo_rd cycle.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      crc <= 16'hFFFF;
    end else if (fifo_rd) begin
      crc <= crc16_byte(crc, tx_byte);
    end
  end
`endif
endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb/tb_usb_tx_ctrl.sv - randomized self-checking bench for usb_tx_ctrl with a packet-level model.
module tb_usb_tx_ctrl;
  localparam int MAX_BYTES = 64;
  localparam int EOP_BITS  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_len = 7'd0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       shift_enable = 1'b0;
  logic       byte_sent = 1'b0;
  logic       fifo_rd, enable_timer, load_byte, eop_se0, eop_j, tx_busy, tx_done, tx_error;
  logic [7:0] tx_byte;

  usb_tx_ctrl #(.MAX_BYTES(MAX_BYTES), .EOP_BITS(EOP_BITS)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .shift_enable(shift_enable), .byte_sent(byte_sent), .enable_timer(enable_timer),
    .tx_byte(tx_byte), .load_byte(load_byte), .eop_se0(eop_se0), .eop_j(eop_j),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         pop;
    bit         first;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, period = 1, tcnt = 0, tbits = 0, last_load = 0;
  int load_cnt = 0, pop_cnt = 0, se0_cyc = 0, j_cyc = 0, done_cnt = 0, err_cnt = 0;
  int s_pop, s_se0, s_j, s_done, s_err;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-serial LFSR over the LSB-first bit stream; returns the transmitted (inverted) value.
  function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    foreach (d[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = d[k][i] ^ r[0];
        r  = {1'b0, r[15:1]};
        if (fb) r = r ^ 16'hA001;
      end
    end
    return ~r;
  endfunction

  task automatic push_exp(input logic [7:0] b, input bit pop, input bit first);
    exp_t e;
    e.b = b; e.pop = pop; e.first = first;
    exp_q.push_back(e);
  endtask

  // One clock: observe the outputs of the last edge, serve the FIFO, then drive the bit timer.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (load_byte) begin
      load_cnt++;
      chk("load_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_byte", tx_byte, e.b);
        chk("fifo_rd_with_load", fifo_rd, e.pop);
        if (!e.first) chk("load_gap", cyc - last_load, 8 * period);
      end
      last_load = cyc;
    end else begin
      chk("fifo_rd_without_load", fifo_rd, 0);
    end
    chk("se0_j_exclusive", eop_se0 & eop_j, 0);
    if (fifo_rd) begin
      pop_cnt++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (eop_se0) se0_cyc++;
    if (eop_j) j_cyc++;
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done || tx_error) begin
      chk("busy_low_at_end", tx_busy, 0);
      chk("busy_before_end", prev_busy, 1);
    end
    prev_busy  = tx_busy;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    shift_enable = 1'b0;
    byte_sent    = 1'b0;
    if (!enable_timer) begin
      tcnt = 0;
      tbits = 0;
    end else begin
      tcnt++;
      if (tcnt == period) begin
        tcnt = 0;
        shift_enable = 1'b1;
        tbits++;
        if (tbits == 8) begin
          tbits = 0;
          byte_sent = 1'b1;
        end
      end
    end
  endtask

  task automatic start_packet(input logic [3:0] pid, input int len, input logic [7:0] pl[$],
                              input int p, output bit underrun, output int k);
    bit          dat;
    int          eff;
    logic [7:0]  sent[$];
    logic [15:0] c;
    dat = (pid == 4'h3) || (pid == 4'hB);
    eff = dat ? ((len > MAX_BYTES) ? MAX_BYTES : len) : 0;
    k = (eff < pl.size()) ? eff : pl.size();
    underrun = (pl.size() < eff);
    period = p;
    exp_q.delete();
    push_exp(8'h80, 1'b0, 1'b1);
    push_exp({~pid, pid}, 1'b0, 1'b0);
    for (int i = 0; i < k; i++) begin
      push_exp(pl[i], 1'b1, 1'b0);
      sent.push_back(pl[i]);
    end
`ifdef USB_TX_CRC16_EN
    if (dat && !underrun) begin
      c = model_crc(sent);
      push_exp(c[7:0], 1'b0, 1'b0);
      push_exp(c[15:8], 1'b0, 1'b0);
    end
`else
    c = 16'h0000;
`endif
    fifo_q = pl;
    s_pop = pop_cnt; s_se0 = se0_cyc; s_j = j_cyc; s_done = done_cnt; s_err = err_cnt;
    tx_pid = pid;
    tx_len = 7'(len);
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_pid = 4'($urandom);
    tx_len = 7'($urandom);
    chk("busy_rise", tx_busy, 1);
  endtask

  task automatic finish_packet(input bit underrun, input int k, input int p);
    int n;
    n = 0;
    while (done_cnt == s_done && err_cnt == s_err && n < 5000) begin
      tick();
      n++;
    end
    chk("completed_in_time", n < 5000, 1);
    tick();
    tick();
    chk("all_loads_sent", exp_q.size(), 0);
    chk("pops", pop_cnt - s_pop, k);
    chk("se0_cycles", se0_cyc - s_se0, underrun ? 1 : EOP_BITS * p);
    chk("j_cycles", j_cyc - s_j, underrun ? 0 : p);
    chk("done_pulses", done_cnt - s_done, underrun ? 0 : 1);
    chk("error_pulses", err_cnt - s_err, underrun ? 1 : 0);
    exp_q.delete();
    fifo_q.delete();
  endtask

  task automatic run_packet(input logic [3:0] pid, input int len, input logic [7:0] pl[$],
                            input int p, input bit mid);
    bit ur;
    int k;
    start_packet(pid, len, pl, p, ur, k);
    if (mid) begin
      repeat (6) tick();
      tx_pid = 4'h2;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
      chk("busy_hold", tx_busy, 1);
    end
    finish_packet(ur, k, p);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_load_byte"}, load_byte, 0);
    chk({tag, "_fifo_rd"}, fifo_rd, 0);
    chk({tag, "_enable_timer"}, enable_timer, 0);
    chk({tag, "_eop_se0"}, eop_se0, 0);
    chk({tag, "_eop_j"}, eop_j, 0);
    chk({tag, "_tx_busy"}, tx_busy, 0);
    chk({tag, "_tx_done"}, tx_done, 0);
    chk({tag, "_tx_error"}, tx_error, 0);
    chk({tag, "_tx_byte"}, tx_byte, 8'h00);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] none[$];
    logic [3:0] legal[5];
    logic [3:0] pid;
    bit ur;
    int k, len, n, l0;

    legal[0] = 4'h2; legal[1] = 4'hA; legal[2] = 4'hE; legal[3] = 4'h3; legal[4] = 4'hB;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    chk("model_crc_check_value", model_crc(pl), 16'hB4C8);

    run_packet(4'h2, 0, none, 2, 1'b0);

    run_packet(4'h3, 0, none, 1, 1'b0);

    pl.delete();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    run_packet(4'hB, 3, pl, 1, 1'b0);

    pl.delete();
    pl.push_back(8'hA5); pl.push_back(8'h5A);
    run_packet(4'h3, 4, pl, 1, 1'b0);

    pl.delete();
    for (int i = 0; i < 70; i++) pl.push_back(8'($urandom));
    run_packet(4'h3, 70, pl, 1, 1'b0);

    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
    start_packet(4'h3, 4, pl, 1, ur, k);
    n = 0;
    while (pop_cnt == s_pop && n < 200) begin
      tick();
      n++;
    end
    chk("reached_data", n < 200, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    tick();
    run_packet(4'h2, 0, none, 1, 1'b0);

    l0 = load_cnt;
    tx_pid = 4'h0;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (20) tick();
    chk("illegal_pid_busy", tx_busy, 0);
    chk("illegal_pid_loads", load_cnt - l0, 0);

    for (int t = 0; t < 25; t++) begin
      pid = legal[$urandom_range(0, 4)];
      len = $urandom_range(0, 10);
      pl.delete();
      if (pid == 4'h3 || pid == 4'hB) begin
        if (len > 0 && $urandom_range(0, 4) == 0) n = $urandom_range(0, len - 1);
        else n = len + $urandom_range(0, 2);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      end
      run_packet(pid, len, pl, $urandom_range(1, 3), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
